leb128_decoder: RTL and testbench
=================================

// Module: leb128_decoder
// PURPOSE
//  Byte-serial LEB128 immediate decoder between the bytecode ROM fetch and the cpu execute stage.
//  Consumes one code byte per handshake and emits the decoded immediate, e.g. for i64.const,
//  i32.const, local/branch indices. Also emits the encoded length, used for the PC advance.
//  Signed (sLEB128) and unsigned (uLEB128) modes are selected per immediate.
// PARAMETERS
//  WIDTH      64  decoded value width (32 or 64)
//  MAX_BYTES  10  max encoded bytes = ceil(WIDTH/7); 10 for 64, 5 for 32
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high; clears all state
//  abort      in   1      sync flush: discards any partial/held value, returns to IDLE
//  in_signed  in   1      1=sLEB128; sampled with first byte only
//  in_byte    in   8      code byte from ROM fetch
//  in_valid   in   1      in_byte valid
//  in_ready   out  1      decoder accepts in_byte this cycle
//  out_value  out  WIDTH  decoded immediate (sign-/zero-extended)
//  out_len    out  4      number of bytes consumed (1..MAX_BYTES)
//  out_error  out  1      malformed encoding; qualifies out_valid
//  out_valid  out  1      result held
//  out_ready  in   1      consumer (cpu) takes result
// BEHAVIOUR
//  - Reset: state=IDLE, out_value=0, out_len=0, out_error=0, out_valid=0, shift=0, count=0.
//  - FSM: IDLE -> ACCUM on an accepted byte with bit7=1. IDLE|ACCUM -> DONE on an accepted
//    byte with bit7=0, or on error. DONE -> IDLE on out_valid&out_ready.
//  - in_ready = !out_valid (IDLE/ACCUM). One bubble cycle between a result handshake and the next byte.
//  - Accept: acc |= byte[6:0] << 7*count; count++. Bits shifted beyond WIDTH are dropped.
//  - Final byte: signed mode with byte[6]=1 -> bits [WIDTH-1 : 7*count] set to 1. Else zero-extend.
//  - Latency: out_valid rises the cycle after the final byte is accepted. Value, len and error
//    are stable until the handshake.
//  - Error: if the MAX_BYTES-th byte still has bit7=1, go to DONE with out_error=1 and
//    out_len=MAX_BYTES. out_value is then don't-care (driven 0). Consumer maps this to a trap.
//  - abort has priority over any handshake in the same cycle; the next cycle is IDLE with
//    out_valid=0.
//  - Reset mid-immediate: partial value lost, no output produced.
//  - out_valid & !out_ready: hold all outputs, in_ready=0 (backpressure to ROM fetch).
// CONFIGURATION
//  - LEB128_STRICT_EN defined: the MAX_BYTES-th byte is range-checked. Its bits above
//    WIDTH-7*(MAX_BYTES-1) must be 0 (unsigned) or equal to the value's sign bit (signed).
//    A violation sets out_error=1. Example for i64: the 10th byte must be 0x00/0x01 (unsigned)
//    or 0x00/0x7F (signed).
//  - Not defined: excess bits are silently truncated and out_error only flags byte-count overrun.
// STRUCTURE
//  - Shared header leb128.vh: state encodings (S_IDLE, S_ACCUM, S_DONE), LEB_CONT_BIT=7,
//    LEB_SIGN_BIT=6, LEB_PAYLOAD=7. The cpu decoder includes it too.
//  - Single flat module, no sub-module. The sign-extension mask is a local function.
// TESTING
//  - signed, 0x2A -> out_value=42, out_len=1, out_error=0, valid 1 cycle after accept
//  - unsigned, 0xE5 0x8E 0x26 -> 624485 (0x98765), out_len=3
//  - signed, 0x7F -> 0xFFFF_FFFF_FFFF_FFFF; signed 0xC0 0xBB 0x78 -> -123456, out_len=3
//  - 0x80 x10 -> out_error=1 at 10th byte, out_len=10; next byte not accepted until handshake
//  - strict: signed 0xFF x9 + 0x7F -> -1, no error. Signed 0xFF x9 + 0x01 -> out_error=1 with
//    LEB128_STRICT_EN only.
//  - out_ready=0 for 5 cycles: outputs stable, in_ready=0. abort asserted after 2 bytes
//    -> IDLE, no out_valid; then 0x2A decodes to 42.

Source files
------------

// File: rtl/leb128_decoder_pkg.sv
// Shared definitions for the byte-serial LEB128 immediate decoder.
package leb128_decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int unsigned LEB_CONT_BIT = 7;  // continuation flag position
    localparam int unsigned LEB_SIGN_BIT = 6;  // sign bit of a final sLEB128 byte
    localparam int unsigned LEB_PAYLOAD  = 7;  // payload bits per byte
    localparam int unsigned LEN_W        = 4;  // width of the encoded-length output
    localparam int unsigned SHIFT_W      = 7;  // holds 7*count up to 70

endpackage

// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder: one code byte per handshake, emits value and encoded length.
// Optional range check of the last permitted byte: define LEB128_STRICT_EN.
module leb128_decoder
    import leb128_decoder_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MAX_BYTES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             in_signed,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [LEN_W-1:0] out_len,
    output logic             out_error,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_next, final_value;
    logic [SHIFT_W-1:0] shift_q, shift_d, shift_next;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               signed_q, signed_d, mode_signed;
    logic [WIDTH-1:0]   out_value_q, out_value_d;
    logic [LEN_W-1:0]   out_len_q, out_len_d;
    logic               out_error_q, out_error_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               accept, is_cont, last_slot, overrun, finish, strict_err, fin_err;

    // Ones from bit lsb upward; an lsb at or beyond WIDTH yields no extension.
    function automatic logic [WIDTH-1:0] sext_mask(input logic [SHIFT_W-1:0] lsb);
        return {WIDTH{1'b1}} << lsb;
    endfunction

    // Byte acceptance and accumulator arithmetic for the byte on the bus.
    always_comb begin
        accept      = in_valid & in_ready_q & ~abort;
        is_cont     = in_byte[LEB_CONT_BIT];
        last_slot   = (count_q == LEN_W'(MAX_BYTES - 1));
        overrun     = is_cont & last_slot;
        finish      = accept & (~is_cont | last_slot);
        mode_signed = (state_q == S_IDLE) ? in_signed : signed_q;
        acc_next    = acc_q | (WIDTH'(in_byte[LEB_PAYLOAD-1:0]) << shift_q);
        shift_next  = shift_q + SHIFT_W'(LEB_PAYLOAD);
        final_value = acc_next;
        if (mode_signed && in_byte[LEB_SIGN_BIT]) begin
            final_value = acc_next | sext_mask(shift_next);
        end
    end

`ifdef LEB128_STRICT_EN
    localparam int unsigned KEEP = WIDTH - LEB_PAYLOAD * (MAX_BYTES - 1);
    localparam logic [LEB_PAYLOAD-1:0] HI_MASK = LEB_PAYLOAD'(7'h7F << KEEP);
    logic [LEB_PAYLOAD-1:0] sign_ref;

    // Last permitted byte: bits above the value width must repeat the sign (or be zero).
    always_comb begin
        sign_ref   = mode_signed ? {LEB_PAYLOAD{in_byte[KEEP-1]}} : '0;
        strict_err = last_slot & ~is_cont
                   & (|((in_byte[LEB_PAYLOAD-1:0] ^ sign_ref) & HI_MASK));
    end
`else
    assign strict_err = 1'b0;
`endif

    assign fin_err = overrun | strict_err;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; abort wins over any handshake.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (accept) state_d = finish ? S_DONE : S_ACCUM;
                S_ACCUM: if (finish) state_d = S_DONE;
                S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        acc_d       = acc_q;
        shift_d     = shift_q;
        count_d     = count_q;
        signed_d    = signed_q;
        out_value_d = out_value_q;
        out_len_d   = out_len_q;
        out_error_d = out_error_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        if (abort) begin
            acc_d       = '0;
            shift_d     = '0;
            count_d     = '0;
            out_error_d = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else if (finish) begin
            acc_d       = '0;
            shift_d     = '0;
            count_d     = '0;
            out_value_d = fin_err ? '0 : final_value;
            out_len_d   = count_q + LEN_W'(1);
            out_error_d = fin_err;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
        end else if (accept) begin
            acc_d    = acc_next;
            shift_d  = shift_next;
            count_d  = count_q + LEN_W'(1);
            signed_d = mode_signed;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            signed_q    <= 1'b0;
            out_value_q <= '0;
            out_len_q   <= '0;
            out_error_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            signed_q    <= signed_d;
            out_value_q <= out_value_d;
            out_len_q   <= out_len_d;
            out_error_q <= out_error_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_value = out_value_q;
    assign out_len   = out_len_q;
    assign out_error = out_error_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Randomised bench for leb128_decoder with an arithmetic reference model.
module tb_leb128_decoder;

    localparam int MAXB = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        in_signed = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_error;
    logic        out_valid;
    logic        out_ready;

    logic        rand_phase = 1'b0;
    logic        dir_or = 1'b1;
    logic        rnd_or = 1'b1;
    assign out_ready = rand_phase ? rnd_or : dir_or;

    int checks = 0;
    int failures = 0;

    // literal expectations posted by the driver, consumed by the monitor
    logic [63:0] lit_v = '0;
    logic [3:0]  lit_len = '0;
    logic        lit_err = 1'b0;
    int          lit_seq = 0;
    int          lit_done = 0;

    leb128_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .in_signed (in_signed),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_len   (out_len),
        .out_error (out_error),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_or = ($urandom_range(0, 9) < 7);
    end

    // Decode as an integer: sum of payload*128^i, minus 128^n for a negative sLEB128.
    function automatic void model_result(input logic [7:0] bq[$], input bit sgn,
                                         output logic [63:0] v, output logic [3:0] len,
                                         output bit err);
        logic signed [127:0] acc;
`ifdef LEB128_STRICT_EN
        logic signed [127:0] lim;
`endif
        int n;
        n = bq.size();
        acc = '0;
        len = 4'(n);
        err = 1'b0;
        v = '0;
        for (int i = 0; i < n; i++) acc = acc + (128'(bq[i][6:0]) << (7 * i));
        if (bq[n-1][7]) begin
            err = 1'b1;
            return;
        end
        if (sgn && bq[n-1][6]) acc = acc - (128'sd1 <<< (7 * n));
`ifdef LEB128_STRICT_EN
        lim = 128'sd1 <<< 63;
        if (sgn) err = (acc >= lim) || (acc < -lim);
        else     err = (acc >= (lim <<< 1));
        if (err) return;
`endif
        v = acc[63:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: bytes of the immediate in progress and the held result.
    logic [7:0]  cur[$];
    bit          cur_s = 1'b0;
    bit          ev = 1'b0;
    bit          fresh = 1'b0;
    logic [63:0] evv = '0;
    logic [3:0]  evl = '0;
    bit          eve = 1'b0;

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            cur.delete();
            ev = 1'b0;
            fresh = 1'b0;
            chk("rst_value", out_value, 64'd0);
            chk("rst_len", 64'(out_len), 64'd0);
            chk("rst_error", 64'(out_error), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(!ev));
            if (ev) begin
                chk("out_value", out_value, evv);
                chk("out_len", 64'(out_len), 64'(evl));
                chk("out_error", 64'(out_error), 64'(eve));
            end
            if (fresh && lit_seq != lit_done) begin
                chk("lit_value", out_value, lit_v);
                chk("lit_len", 64'(out_len), 64'(lit_len));
                chk("lit_error", 64'(out_error), 64'(lit_err));
                lit_done = lit_seq;
            end
            fresh = 1'b0;
            if (abort) begin
                cur.delete();
                ev = 1'b0;
            end else if (ev) begin
                if (out_ready) ev = 1'b0;
            end else if (in_valid) begin
                if (cur.size() == 0) cur_s = in_signed;
                cur.push_back(in_byte);
                if (!in_byte[7] || cur.size() == MAXB) begin
                    model_result(cur, cur_s, evv, evl, eve);
                    ev = 1'b1;
                    fresh = 1'b1;
                    cur.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit s);
        in_valid = 1'b1;
        in_byte = b;
        in_signed = s;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready && !abort) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        $display("FAIL send_timeout byte=%0h never accepted", b);
        $fatal(1, "send timeout");
    endtask

    task automatic send_imm(input logic [7:0] bq[$], input bit s);
        foreach (bq[i]) send_byte(bq[i], s);
    endtask

    task automatic set_lit(input logic [63:0] v, input logic [3:0] l, input logic e);
        lit_v = v;
        lit_len = l;
        lit_err = e;
        lit_seq++;
    endtask

    task automatic wait_lit();
        for (int k = 0; k < 100; k++) begin
            if (lit_done == lit_seq) return;
            tick();
        end
        $display("FAIL lit_timeout result never appeared seq=%0d", lit_seq);
        $fatal(1, "result timeout");
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        int n;
        bit ovr, s;

        repeat (2) tick();
        reset = 1'b0;
        tick();

        set_lit(64'd42, 4'd1, 1'b0);
        send_byte(8'h2A, 1'b1);
        wait_lit();

        q = {8'hE5, 8'h8E, 8'h26};
        set_lit(64'h98765, 4'd3, 1'b0);
        send_imm(q, 1'b0);
        wait_lit();

        set_lit(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
        send_byte(8'h7F, 1'b1);
        wait_lit();

        q = {8'hC0, 8'hBB, 8'h78};
        set_lit(64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
        send_imm(q, 1'b1);
        wait_lit();

        set_lit(64'd127, 4'd1, 1'b0);
        send_byte(8'h7F, 1'b0);
        wait_lit();

        // overrun, held under backpressure with the next byte waiting
        dir_or = 1'b0;
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(8'h80);
        set_lit(64'd0, 4'd10, 1'b1);
        send_imm(q, 1'b0);
        wait_lit();
        set_lit(64'd42, 4'd1, 1'b0);
        in_valid = 1'b1;
        in_byte = 8'h2A;
        in_signed = 1'b1;
        repeat (3) tick();
        dir_or = 1'b1;
        send_byte(8'h2A, 1'b1);
        wait_lit();

        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'hFF);
        q.push_back(8'h7F);
        set_lit(64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
        send_imm(q, 1'b1);
        wait_lit();

        q[9] = 8'h01;
`ifdef LEB128_STRICT_EN
        set_lit(64'd0, 4'd10, 1'b1);
`else
        set_lit(64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
`endif
        send_imm(q, 1'b1);
        wait_lit();

        // hold for five cycles
        dir_or = 1'b0;
        set_lit(64'd42, 4'd1, 1'b0);
        send_byte(8'h2A, 1'b1);
        wait_lit();
        repeat (5) tick();
        dir_or = 1'b1;
        repeat (2) tick();

        // abort after two bytes
        q = {8'h80, 8'h81};
        send_imm(q, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        set_lit(64'd42, 4'd1, 1'b0);
        send_byte(8'h2A, 1'b1);
        wait_lit();

        // reset mid-immediate
        q = {8'h80, 8'h80};
        send_imm(q, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        set_lit(64'd42, 4'd1, 1'b0);
        send_byte(8'h2A, 1'b1);
        wait_lit();

        // randomised traffic
        rand_phase = 1'b1;
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 29) == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            n = $urandom_range(1, 10);
            ovr = ($urandom_range(0, 9) == 0);
            if (ovr) n = 10;
            s = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 127));
                if (i == 9 && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0: b = 8'h00;
                        1: b = 8'h01;
                        2: b = 8'h7F;
                        default: b = 8'h7E;
                    endcase
                end
                b[7] = ovr ? 1'b1 : (i < n - 1);
                if (i > 0 && $urandom_range(0, 39) == 0) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                end
                if (i > 0 && $urandom_range(0, 4) == 0) tick();
                send_byte(b, (i == 0) ? s : 1'($urandom_range(0, 1)));
            end
        end
        rand_phase = 1'b0;
        dir_or = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
